// File: rtl/id_hazard_ctrl_if.sv
// Shared types and the decode-hazard bundle: pipeline stage info,
// cache stalls and flush request in; forward/NOP/load/flush/counters out.
package id_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        FWD_ID      = 3'd0,
        FWD_EX      = 3'd1,
        FWD_MEM_ALU = 3'd2,
        FWD_MEM_LD  = 3'd3,
        FWD_WB_ALU  = 3'd4,
        FWD_WB_LD   = 3'd5
    } fwd_sel_t;

    typedef fwd_sel_t forwardingmux3_sel_t;
    typedef fwd_sel_t forwardingmux4_sel_t;

    typedef enum logic {
        CTRL_ZERO   = 1'b0,
        CTRL_NORMAL = 1'b1
    } controlmux_sel_t;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

interface id_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import id_hazard_ctrl_pkg::*;

    logic [6:0]          id_opcode_i;
    logic [4:0]          id_rs1_i;
    logic [4:0]          id_rs2_i;
    logic [4:0]          ex_rd_i;
    logic                ex_load_regfile_i;
    logic                ex_mem_read_i;
    logic [4:0]          mem_rd_i;
    logic                mem_load_regfile_i;
    logic                mem_mem_read_i;
    logic [4:0]          wb_rd_i;
    logic                wb_load_regfile_i;
    logic                wb_mem_read_i;
    logic                icache_stall_i;
    logic                dcache_stall_i;
    logic                id_flush_req_i;
    forwardingmux3_sel_t forwardD_o;
    forwardingmux4_sel_t forwardE_o;
    controlmux_sel_t     controlmux_sel_o;
    logic                pc_load_o;
    logic                if_id_load_o;
    logic                pipe_load_o;
    logic                if_id_flush_o;
    logic [CNT_W-1:0]    stall_cnt_o;
    logic [CNT_W-1:0]    flush_cnt_o;

    modport slave (
        input  id_opcode_i, id_rs1_i, id_rs2_i,
        input  ex_rd_i, ex_load_regfile_i, ex_mem_read_i,
        input  mem_rd_i, mem_load_regfile_i, mem_mem_read_i,
        input  wb_rd_i, wb_load_regfile_i, wb_mem_read_i,
        input  icache_stall_i, dcache_stall_i, id_flush_req_i,
        output forwardD_o, forwardE_o, controlmux_sel_o,
        output pc_load_o, if_id_load_o, pipe_load_o,
        output if_id_flush_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output id_opcode_i, id_rs1_i, id_rs2_i,
        output ex_rd_i, ex_load_regfile_i, ex_mem_read_i,
        output mem_rd_i, mem_load_regfile_i, mem_mem_read_i,
        output wb_rd_i, wb_load_regfile_i, wb_mem_read_i,
        output icache_stall_i, dcache_stall_i, id_flush_req_i,
        input  forwardD_o, forwardE_o, controlmux_sel_o,
        input  pc_load_o, if_id_load_o, pipe_load_o,
        input  if_id_flush_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller: forward selects, load-use
// bubble, cache-miss freeze with deferred flush, saturating counters.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    id_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE =
        {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic      rs1_used, rs2_used;
    logic      frz, lu;
    fwd_sel_t  fwd1, fwd2;
    logic      ctrl_zero;
    logic      pc_ld, ifid_ld, pipe_ld;
    logic      flush;
    logic      stall_inc;

    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] src,
        input logic       used
    );
        fwd_sel_t s;
        s = FWD_ID;
        if (!used || src == 5'd0) begin
            s = FWD_ID;
        end else if (bus.ex_load_regfile_i &&
                     !bus.ex_mem_read_i &&
                     bus.ex_rd_i == src) begin
            s = FWD_EX;
        end else if (bus.mem_load_regfile_i &&
                     bus.mem_rd_i == src) begin
            s = bus.mem_mem_read_i ? FWD_MEM_LD
                                   : FWD_MEM_ALU;
        end else if (bus.wb_load_regfile_i &&
                     bus.wb_rd_i == src) begin
            s = bus.wb_mem_read_i ? FWD_WB_LD
                                  : FWD_WB_ALU;
        end
        return s;
    endfunction

    always_comb begin
        rs1_used = (bus.id_opcode_i == OP_BR) ||
                   (bus.id_opcode_i == OP_JALR);
        rs2_used = (bus.id_opcode_i == OP_BR);
        fwd1 = fwd_pick(bus.id_rs1_i, rs1_used);
        fwd2 = fwd_pick(bus.id_rs2_i, rs2_used);
        frz  = bus.icache_stall_i | bus.dcache_stall_i;
        lu   = bus.ex_mem_read_i && (bus.ex_rd_i != 5'd0) &&
               ((rs1_used && bus.ex_rd_i == bus.id_rs1_i) ||
                (rs2_used && bus.ex_rd_i == bus.id_rs2_i));
    end

    // A cache stall freezes the pipe in the same cycle it is seen,
    // whatever the registered state; the FREEZE state then marks the
    // next unstalled cycle as the one that releases a held flush.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ctrl_zero = 1'b0;
        pc_ld     = 1'b1;
        ifid_ld   = 1'b1;
        pipe_ld   = 1'b1;
        flush     = 1'b0;
        stall_inc = 1'b0;
        if (frz) begin
            state_d   = FREEZE;
            pending_d = pending_q | bus.id_flush_req_i;
            pc_ld     = 1'b0;
            ifid_ld   = 1'b0;
            pipe_ld   = 1'b0;
            stall_inc = 1'b1;
        end else begin
            unique case (state_q)
                LU_STALL: begin
                    // branch operands were stale: no flush
                    state_d   = RUN;
                    pending_d = 1'b0;
                end
                RUN, FREEZE: begin
                    pending_d = 1'b0;
                    if (lu) begin
                        state_d   = LU_STALL;
                        ctrl_zero = 1'b1;
                        pc_ld     = 1'b0;
                        ifid_ld   = 1'b0;
                        stall_inc = 1'b1;
                        flush     = pending_q;
                    end else begin
                        state_d = RUN;
                        flush   = pending_q |
                                  bus.id_flush_req_i;
                    end
                end
                default: begin
                    state_d   = RUN;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.forwardD_o = rst ? FWD_ID : fwd1;
    assign bus.forwardE_o = rst ? FWD_ID : fwd2;
    assign bus.controlmux_sel_o =
        (ctrl_zero && !rst) ? CTRL_ZERO : CTRL_NORMAL;
    assign bus.pc_load_o     = pc_ld | rst;
    assign bus.if_id_load_o  = ifid_ld | rst;
    assign bus.pipe_load_o   = pipe_ld | rst;
    assign bus.if_id_flush_o = flush & ~rst;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: fixed vectors, hand-written multi-cycle
// sequences and random stimulus against a behavioural model.
module tb_id_hazard_ctrl;
    import id_hazard_ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    id_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    id_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit m_after;
    bit m_pend;
    int m_stall;
    int m_flush;
    // model expectations for the current cycle
    fwd_sel_t e_fd, e_fe;
    bit e_ctrl, e_pc, e_ifid, e_pipe, e_flush, e_bub, e_frz;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic fwd_sel_t m_fwd(input int idx, input bit used);
        int rd[3];
        bit wr[3];
        bit ld[3];
        rd[0] = int'(bus.ex_rd_i);
        wr[0] = bus.ex_load_regfile_i;
        ld[0] = bus.ex_mem_read_i;
        rd[1] = int'(bus.mem_rd_i);
        wr[1] = bus.mem_load_regfile_i;
        ld[1] = bus.mem_mem_read_i;
        rd[2] = int'(bus.wb_rd_i);
        wr[2] = bus.wb_load_regfile_i;
        ld[2] = bus.wb_mem_read_i;
        if (!used || idx == 0) return FWD_ID;
        for (int k = 0; k < 3; k++) begin
            if (wr[k] && rd[k] == idx) begin
                if (k == 0 && !ld[k]) return FWD_EX;
                if (k == 1) return ld[k] ? FWD_MEM_LD : FWD_MEM_ALU;
                if (k == 2) return ld[k] ? FWD_WB_LD : FWD_WB_ALU;
            end
        end
        return FWD_ID;
    endfunction

    task automatic compute_exp();
        bit u1, u2, lu;
        int r1, r2, ed;
        u1 = (bus.id_opcode_i == OP_BR) ||
             (bus.id_opcode_i == OP_JALR);
        u2 = (bus.id_opcode_i == OP_BR);
        r1 = int'(bus.id_rs1_i);
        r2 = int'(bus.id_rs2_i);
        ed = int'(bus.ex_rd_i);
        e_fd  = m_fwd(r1, u1);
        e_fe  = m_fwd(r2, u2);
        e_frz = bus.icache_stall_i || bus.dcache_stall_i;
        lu = bus.ex_mem_read_i && ed != 0 &&
             ((u1 && ed == r1) || (u2 && ed == r2));
        e_ctrl = 1; e_pc = 1; e_ifid = 1; e_pipe = 1;
        e_flush = 0; e_bub = 0;
        if (rst) begin
            m_after = 0; m_pend = 0; m_stall = 0; m_flush = 0;
            e_fd = FWD_ID; e_fe = FWD_ID; e_frz = 0;
        end else if (e_frz) begin
            e_pc = 0; e_ifid = 0; e_pipe = 0;
        end else if (m_after) begin
            e_flush = 0;
        end else if (lu) begin
            e_bub = 1; e_ctrl = 0; e_pc = 0; e_ifid = 0;
            e_flush = m_pend;
        end else begin
            e_flush = bus.id_flush_req_i || m_pend;
        end
    endtask

    task automatic check_model();
        compute_exp();
        chk("fwdD", int'(bus.forwardD_o), int'(e_fd));
        chk("fwdE", int'(bus.forwardE_o), int'(e_fe));
        chk("ctrl", int'(bus.controlmux_sel_o), int'(e_ctrl));
        chk("pc_load", int'(bus.pc_load_o), int'(e_pc));
        chk("if_id_load", int'(bus.if_id_load_o), int'(e_ifid));
        chk("pipe_load", int'(bus.pipe_load_o), int'(e_pipe));
        chk("flush", int'(bus.if_id_flush_o), int'(e_flush));
        chk("stall_cnt", int'(bus.stall_cnt_o), m_stall);
        chk("flush_cnt", int'(bus.flush_cnt_o), m_flush);
    endtask

    // negedge check, then advance the model across the posedge
    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        if (!rst) begin
            if (e_frz || e_bub) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (e_flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            m_pend  = e_frz ? (m_pend || bus.id_flush_req_i) : 0;
            m_after = e_bub;
        end
        #1;
    endtask

    task automatic clear_in();
        bus.id_opcode_i = 7'h13;
        bus.id_rs1_i = 0; bus.id_rs2_i = 0;
        bus.ex_rd_i = 0; bus.ex_load_regfile_i = 0;
        bus.ex_mem_read_i = 0;
        bus.mem_rd_i = 0; bus.mem_load_regfile_i = 0;
        bus.mem_mem_read_i = 0;
        bus.wb_rd_i = 0; bus.wb_load_regfile_i = 0;
        bus.wb_mem_read_i = 0;
        bus.icache_stall_i = 0; bus.dcache_stall_i = 0;
        bus.id_flush_req_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
        m_after = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1, rs2;
        logic [4:0] exrd;  logic exw, exl;
        logic [4:0] memrd; logic memw, meml;
        logic [4:0] wbrd;  logic wbw, wbl;
        logic       req;
        fwd_sel_t   efd, efe;
        logic       ebub, eflush;
    } vec_t;

    vec_t tv[12];

    initial begin
        rst = 1;
        clear_in();
        tv[0]  = '{OP_BR,5,0,   5,1,0, 5,1,1, 0,0,0, 0,
                   FWD_EX,FWD_ID,0,0};
        tv[1]  = '{OP_BR,7,8,   7,1,1, 0,0,0, 0,0,0, 1,
                   FWD_ID,FWD_ID,1,0};
        tv[2]  = '{OP_JALR,3,9, 9,1,1, 0,0,0, 0,0,0, 0,
                   FWD_ID,FWD_ID,0,0};
        tv[3]  = '{OP_BR,0,0,   0,1,1, 0,1,0, 0,1,0, 0,
                   FWD_ID,FWD_ID,0,0};
        tv[4]  = '{OP_BR,4,6,   0,0,0, 4,1,0, 6,1,1, 0,
                   FWD_MEM_ALU,FWD_WB_LD,0,0};
        tv[5]  = '{OP_BR,4,6,   0,0,0, 6,1,1, 4,1,0, 0,
                   FWD_WB_ALU,FWD_MEM_LD,0,0};
        tv[6]  = '{OP_BR,2,2,   0,0,0, 2,1,0, 2,1,1, 0,
                   FWD_MEM_ALU,FWD_MEM_ALU,0,0};
        tv[7]  = '{7'h33,5,5,   5,1,0, 5,1,0, 5,1,0, 1,
                   FWD_ID,FWD_ID,0,1};
        tv[8]  = '{OP_JALR,5,5, 5,1,0, 0,0,0, 0,0,0, 0,
                   FWD_EX,FWD_ID,0,0};
        tv[9]  = '{OP_BR,1,2,   0,0,0, 0,0,0, 0,0,0, 1,
                   FWD_ID,FWD_ID,0,1};
        tv[10] = '{OP_BR,3,3,   0,0,0, 3,0,1, 3,1,0, 0,
                   FWD_WB_ALU,FWD_WB_ALU,0,0};
        tv[11] = '{OP_BR,1,2,   2,1,1, 0,0,0, 0,0,0, 0,
                   FWD_ID,FWD_ID,1,0};

        @(posedge clk);
        #1;
        // reset state while rst is high
        chk("rst_pc", int'(bus.pc_load_o), 1);
        chk("rst_flush", int'(bus.if_id_flush_o), 0);
        chk("rst_stall_cnt", int'(bus.stall_cnt_o), 0);

        foreach (tv[i]) begin
            rst = 1;
            clear_in();
            bus.id_opcode_i = tv[i].op;
            bus.id_rs1_i = tv[i].rs1;
            bus.id_rs2_i = tv[i].rs2;
            bus.ex_rd_i = tv[i].exrd;
            bus.ex_load_regfile_i = tv[i].exw;
            bus.ex_mem_read_i = tv[i].exl;
            bus.mem_rd_i = tv[i].memrd;
            bus.mem_load_regfile_i = tv[i].memw;
            bus.mem_mem_read_i = tv[i].meml;
            bus.wb_rd_i = tv[i].wbrd;
            bus.wb_load_regfile_i = tv[i].wbw;
            bus.wb_mem_read_i = tv[i].wbl;
            bus.id_flush_req_i = tv[i].req;
            #2 rst = 0;
            @(negedge clk);
            chk($sformatf("v%0d_fwdD", i),
                int'(bus.forwardD_o), int'(tv[i].efd));
            chk($sformatf("v%0d_fwdE", i),
                int'(bus.forwardE_o), int'(tv[i].efe));
            chk($sformatf("v%0d_ctrl", i),
                int'(bus.controlmux_sel_o), int'(!tv[i].ebub));
            chk($sformatf("v%0d_pc", i),
                int'(bus.pc_load_o), int'(!tv[i].ebub));
            chk($sformatf("v%0d_ifid", i),
                int'(bus.if_id_load_o), int'(!tv[i].ebub));
            chk($sformatf("v%0d_pipe", i),
                int'(bus.pipe_load_o), 1);
            chk($sformatf("v%0d_flush", i),
                int'(bus.if_id_flush_o), int'(tv[i].eflush));
            @(posedge clk);
            #1;
        end

        // load-use bubble, then forward from MEM as a load
        clear_in();
        do_reset();
        bus.id_opcode_i = OP_BR;
        bus.id_rs1_i = 7; bus.id_rs2_i = 8;
        bus.ex_rd_i = 7; bus.ex_load_regfile_i = 1;
        bus.ex_mem_read_i = 1;
        cycle();
        chk("lu_bubble_seen", int'(e_bub), 1);
        bus.ex_rd_i = 0; bus.ex_load_regfile_i = 0;
        bus.ex_mem_read_i = 0;
        bus.mem_rd_i = 7; bus.mem_load_regfile_i = 1;
        bus.mem_mem_read_i = 1;
        bus.id_flush_req_i = 1;
        @(negedge clk);
        chk("lu_fwdD_memld", int'(bus.forwardD_o), int'(FWD_MEM_LD));
        chk("lu_stall_cnt", int'(bus.stall_cnt_o), 1);
        chk("lu_flush_supp", int'(bus.if_id_flush_o), 0);
        @(posedge clk);
        #1;

        // freeze 3 cycles, flush request in freeze cycle 2
        clear_in();
        do_reset();
        bus.id_opcode_i = OP_BR;
        for (int c = 1; c <= 4; c++) begin
            bus.dcache_stall_i = (c <= 3);
            bus.id_flush_req_i = (c == 2);
            cycle();
            chk($sformatf("frz_c%0d_pc", c),
                int'(e_pc), int'(c == 4));
            chk($sformatf("frz_c%0d_flush", c),
                int'(e_flush), int'(c == 4));
        end
        clear_in();
        @(negedge clk);
        chk("frz_flush_cnt", int'(bus.flush_cnt_o), 1);
        chk("frz_stall_cnt", int'(bus.stall_cnt_o), 3);
        chk("frz_no_flush", int'(bus.if_id_flush_o), 0);
        @(posedge clk);
        #1;

        // async reset mid-freeze with a pending flush
        clear_in();
        do_reset();
        bus.dcache_stall_i = 1;
        bus.id_flush_req_i = 1;
        cycle();
        bus.id_flush_req_i = 0;
        #1 rst = 1;
        #1;
        chk("arst_stall_cnt", int'(bus.stall_cnt_o), 0);
        chk("arst_pc", int'(bus.pc_load_o), 1);
        chk("arst_flush", int'(bus.if_id_flush_o), 0);
        bus.dcache_stall_i = 0;
        rst = 0;
        m_after = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        cycle();
        chk("arst_no_pend_flush", int'(bus.if_id_flush_o), 0);
        cycle();

        // saturation of the stall counter
        clear_in();
        do_reset();
        bus.icache_stall_i = 1;
        repeat (CMAX + 3) cycle();
        chk("sat_stall_cnt", int'(bus.stall_cnt_o), CMAX);

        // random stimulus against the model
        clear_in();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int opk;
            opk = $urandom_range(0, 3);
            bus.id_opcode_i = (opk == 0) ? OP_BR :
                              (opk == 1) ? OP_JALR :
                              (opk == 2) ? 7'h33 : 7'h03;
            bus.id_rs1_i = 5'($urandom_range(0, 3));
            bus.id_rs2_i = 5'($urandom_range(0, 3));
            bus.ex_rd_i = 5'($urandom_range(0, 3));
            bus.ex_load_regfile_i = 1'($urandom);
            bus.ex_mem_read_i = 1'($urandom);
            bus.mem_rd_i = 5'($urandom_range(0, 3));
            bus.mem_load_regfile_i = 1'($urandom);
            bus.mem_mem_read_i = 1'($urandom);
            bus.wb_rd_i = 5'($urandom_range(0, 3));
            bus.wb_load_regfile_i = 1'($urandom);
            bus.wb_mem_read_i = 1'($urandom);
            bus.icache_stall_i = ($urandom_range(0, 7) == 0);
            bus.dcache_stall_i = ($urandom_range(0, 5) == 0);
            bus.id_flush_req_i = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
